// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush to NOP_VAL and saturating stall/flush event counters.
module pipe_stage_reg #(
   parameter int unsigned          DATA_W  = 64,
   parameter logic [DATA_W-1:0]    NOP_VAL = {DATA_W{1'b0}},
   parameter int unsigned          CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;
   logic              accept, deliver;

   assign accept  = in_valid & in_ready_q;
   assign deliver = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // A deliver this cycle has already been sampled downstream.
         state_d = S_EMPTY;
         main_d  = NOP_VAL;
         skid_d  = NOP_VAL;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d = S_ONE;
                  main_d  = in_data;
               end
            end
            S_ONE: begin
               if (accept && deliver) begin
                  main_d = in_data;
               end else if (accept) begin
                  state_d = S_FULL;
                  skid_d  = in_data;
               end else if (deliver) begin
                  state_d = S_EMPTY;
                  main_d  = NOP_VAL;
               end
            end
            S_FULL: begin
               if (deliver) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_VAL;
               end
            end
            default: begin
               state_d = S_EMPTY;
               main_d  = NOP_VAL;
               skid_d  = NOP_VAL;
            end
         endcase
      end
      out_valid_d = (state_d != S_EMPTY);
      in_ready_d  = (state_d != S_FULL);
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (cnt_clr) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if (out_valid_q && !out_ready && stall_q != CNT_MAX)
            stall_d = stall_q + CNT_ONE;
         if (flush && state_q != S_EMPTY && flush_q != CNT_MAX)
            flush_d = flush_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         main_q      <= NOP_VAL;
         skid_q      <= NOP_VAL;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         stall_q     <= '0;
         flush_q     <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         stall_q     <= stall_d;
         flush_q     <= flush_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic
// compared against a queue-based model of the stage.
module tb_pipe_stage_reg;

   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 4;
   localparam logic [DW-1:0] NOP = 32'hDEAD_BEEF;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic          flush, cnt_clr;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   bit  m_rdy;
   int  m_stall, m_flush;

   pipe_stage_reg #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .flush(flush), .cnt_clr(cnt_clr),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_rdy   = 1'b1;
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".ov"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk({tag, ".od"}, out_data, (mq.size() > 0) ? mq[0] : NOP);
      chk({tag, ".ir"}, {31'd0, in_ready}, {31'd0, m_rdy});
      chk({tag, ".sc"}, {28'd0, stall_cnt}, m_stall);
      chk({tag, ".fc"}, {28'd0, flush_cnt}, m_flush);
   endtask

   // Advance one clock: update the model from the inputs, then compare.
   task automatic step(input string tag);
      bit acc, del;
      acc = in_valid && m_rdy;
      del = (mq.size() > 0) && out_ready;
      if (cnt_clr) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (mq.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
         if (flush && mq.size() > 0 && m_flush < CMAX) m_flush++;
      end
      if (flush) mq.delete();
      else begin
         if (del) void'(mq.pop_front());
         if (acc) mq.push_back(in_data);
      end
      m_rdy = (mq.size() < 2);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   initial begin
      rst_n = 1'b1;
      drive(0, '0, 1);
      flush = 0;
      cnt_clr = 0;
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      check_model("reset");
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming
      drive(1, 32'h11, 1); step("s1"); chk("s1.data", out_data, 32'h11);
      drive(1, 32'h22, 1); step("s2"); chk("s2.data", out_data, 32'h22);
      drive(1, 32'h33, 1); step("s3"); chk("s3.data", out_data, 32'h33);
      chk("s3.rdy", {31'd0, in_ready}, 32'd1);
      drive(0, '0, 1); step("s4");

      // Skid
      drive(1, 32'hA, 1); step("k1");
      drive(1, 32'hB, 0); step("k2");
      chk("k2.rdy", {31'd0, in_ready}, 32'd0);
      chk("k2.data", out_data, 32'hA);
      drive(0, '0, 0); step("k3");
      drive(0, '0, 0); step("k4");
      chk("k4.stall", {28'd0, stall_cnt}, 32'd3);
      drive(0, '0, 1); step("k5");
      chk("k5.data", out_data, 32'hB);
      chk("k5.rdy", {31'd0, in_ready}, 32'd1);
      step("k6");

      // Flush in FULL, then flush while EMPTY
      drive(1, 32'h1, 1); step("f1");
      drive(1, 32'h2, 0); step("f2");
      drive(1, 32'hC, 0); flush = 1; step("f3");
      chk("f3.ov", {31'd0, out_valid}, 32'd0);
      chk("f3.od", out_data, NOP);
      chk("f3.fc", {28'd0, flush_cnt}, 32'd1);
      drive(0, '0, 1); step("f4");
      chk("f4.fc", {28'd0, flush_cnt}, 32'd1);
      flush = 0;
      step("f5");

      // Async reset while FULL
      drive(1, 32'h3, 0); step("r1");
      drive(1, 32'h4, 0); step("r2");
      drive(0, '0, 0);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_model("areset");
      chk("areset.rdy", {31'd0, in_ready}, 32'd1);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1, 32'h5, 1); step("r3");
      chk("r3.data", out_data, 32'h5);
      drive(0, '0, 1); step("r4");

      // Counter saturation and clear priority
      drive(1, 32'h77, 0); step("t0");
      drive(0, '0, 0);
      for (int i = 0; i < 20; i++) step("sat");
      chk("sat.stall", {28'd0, stall_cnt}, 32'd15);
      cnt_clr = 1; step("clr");
      chk("clr.stall", {28'd0, stall_cnt}, 32'd0);
      cnt_clr = 0;

      // Randomized traffic
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) != 0);
         flush   = $urandom_range(0, 31) == 0;
         cnt_clr = $urandom_range(0, 63) == 0;
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
